// File: rtl/ocram_arb_pkg.sv
// Shared widths and types for the two-master OCRAM round-robin arbiter.
package ocram_arb_pkg;

  localparam int unsigned OCRAM_ADDR_W = 13;
  localparam int unsigned OCRAM_DATA_W = 16;
  localparam int unsigned OCRAM_BE_W   = 2;

  // Index of a requester; 0 = m0, 1 = m1.
  typedef logic grant_idx_t;

  // One stage of the read-return pipeline.
  typedef struct packed {
    logic       valid;
    grant_idx_t id;
  } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a one-bit last-grant priority register.
module rr_arb2
  import ocram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  grant_idx_t last_grant_q, last_grant_d;

  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      unique case (req_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        // Under contention the requester that did not win last time goes first.
        2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end

    last_grant_d = last_grant_q;
    if (grant_o[1]) begin
      last_grant_d = 1'b1;
    end else if (grant_o[0]) begin
      last_grant_d = 1'b0;
    end
  end

  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/ocram_rr_arbiter.sv
// Round-robin arbiter sharing the single-port data OCRAM between two Avalon-MM masters,
// with a readdatavalid pipeline matched to the RAM read latency.
module ocram_rr_arbiter
  import ocram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = OCRAM_ADDR_W,
  parameter int unsigned DATA_W       = OCRAM_DATA_W,
  parameter int unsigned BE_W         = OCRAM_BE_W,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_req,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  logic [1:0] req;
  logic [1:0] grant;
  logic       rd_grant;
  grant_idx_t gnt_idx;
  rd_tag_t    rd_out;

  rd_tag_t [READ_LATENCY-1:0] rd_pipe_d, rd_pipe_q;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset   (reset),
    .en_i    (~reset & ~reset_req),
    .req_i   (req),
    .grant_o (grant)
  );

  assign m0_waitrequest = req[0] & ~grant[0];
  assign m1_waitrequest = req[1] & ~grant[1];

  assign ram_chipselect = |grant;
  assign ram_clken      = 1'b1;
  assign gnt_idx        = grant[1];

  // A read issued together with a write is dropped; the write wins.
  always_comb begin
    ram_address    = '0;
    ram_byteenable = '0;
    ram_write      = 1'b0;
    ram_writedata  = '0;
    rd_grant       = 1'b0;
    unique case (grant)
      2'b01: begin
        ram_address    = m0_address;
        ram_byteenable = m0_byteenable;
        ram_write      = m0_write;
        ram_writedata  = m0_writedata;
        rd_grant       = m0_read & ~m0_write;
      end
      2'b10: begin
        ram_address    = m1_address;
        ram_byteenable = m1_byteenable;
        ram_write      = m1_write;
        ram_writedata  = m1_writedata;
        rd_grant       = m1_read & ~m1_write;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_pipe_d       = rd_pipe_q;
    rd_pipe_d[0]    = '{valid: rd_grant, id: gnt_idx};
    for (int unsigned s = 1; s < READ_LATENCY; s++) begin
      rd_pipe_d[s] = rd_pipe_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pipe_q <= '0;
    end else begin
      rd_pipe_q <= rd_pipe_d;
    end
  end

  assign rd_out           = rd_pipe_q[READ_LATENCY-1];
  assign m0_readdatavalid = rd_out.valid & (rd_out.id == 1'b0);
  assign m1_readdatavalid = rd_out.valid & (rd_out.id == 1'b1);
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(m0_read && m0_write))
        else $warning("m0 read and write together; read dropped");
      assert (!(m1_read && m1_write))
        else $warning("m1 read and write together; read dropped");
    end
  end

endmodule

// File: tb/tb_ocram_rr_arbiter.sv
// Directed bench for ocram_rr_arbiter at read latency 1 and 2, with behavioural OCRAMs
// and a per-instance scoreboard of expected {master, data} read returns.
module tb_ocram_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reset_req;
  logic [12:0] m0_address, m1_address;
  logic [1:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [15:0] m0_writedata, m1_writedata;

  // Instance 1: READ_LATENCY = 1
  logic        d1_wait0, d1_wait1, d1_rdv0, d1_rdv1, d1_cs, d1_wr, d1_clken;
  logic [15:0] d1_rdata0, d1_rdata1, d1_wdata, ram1_rd;
  logic [12:0] d1_addr;
  logic [1:0]  d1_be;
  // Instance 2: READ_LATENCY = 2
  logic        d2_wait0, d2_wait1, d2_rdv0, d2_rdv1, d2_cs, d2_wr, d2_clken;
  logic [15:0] d2_rdata0, d2_rdata1, d2_wdata, ram2_rd, ram2_rd_a;
  logic [12:0] d2_addr;
  logic [1:0]  d2_be;

  ocram_rr_arbiter #(.READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(d1_wait0),
    .m0_readdata(d1_rdata0), .m0_readdatavalid(d1_rdv0),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(d1_wait1),
    .m1_readdata(d1_rdata1), .m1_readdatavalid(d1_rdv1),
    .ram_address(d1_addr), .ram_byteenable(d1_be), .ram_chipselect(d1_cs),
    .ram_write(d1_wr), .ram_writedata(d1_wdata), .ram_clken(d1_clken),
    .ram_readdata(ram1_rd)
  );

  ocram_rr_arbiter #(.READ_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(d2_wait0),
    .m0_readdata(d2_rdata0), .m0_readdatavalid(d2_rdv0),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(d2_wait1),
    .m1_readdata(d2_rdata1), .m1_readdatavalid(d2_rdv1),
    .ram_address(d2_addr), .ram_byteenable(d2_be), .ram_chipselect(d2_cs),
    .ram_write(d2_wr), .ram_writedata(d2_wdata), .ram_clken(d2_clken),
    .ram_readdata(ram2_rd)
  );

  // Behavioural OCRAMs
  logic [15:0] mem1 [8192];
  logic [15:0] mem2 [8192];

  always @(posedge clk) begin
    if (d1_cs) begin
      if (d1_wr) begin
        if (d1_be[0]) mem1[d1_addr][7:0]  <= d1_wdata[7:0];
        if (d1_be[1]) mem1[d1_addr][15:8] <= d1_wdata[15:8];
      end else begin
        ram1_rd <= mem1[d1_addr];
      end
    end
  end

  always @(posedge clk) begin
    if (d2_cs) begin
      if (d2_wr) begin
        if (d2_be[0]) mem2[d2_addr][7:0]  <= d2_wdata[7:0];
        if (d2_be[1]) mem2[d2_addr][15:8] <= d2_wdata[15:8];
      end else begin
        ram2_rd_a <= mem2[d2_addr];
      end
    end
    ram2_rd <= ram2_rd_a;
  end

  int errors = 0;
  int checks = 0;
  logic [16:0] q1[$];
  logic [16:0] q2[$];
  logic [16:0] e1, e2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_both(input logic id, input logic [15:0] data);
    q1.push_back({id, data});
    q2.push_back({id, data});
  endtask

  task automatic idle();
    m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_writedata = '0; m0_byteenable = '0;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
  endtask

  task automatic set_m0(input logic r, input logic w, input logic [12:0] a,
                        input logic [15:0] d, input logic [1:0] be);
    m0_read = r; m0_write = w; m0_address = a; m0_writedata = d; m0_byteenable = be;
  endtask

  task automatic set_m1(input logic r, input logic w, input logic [12:0] a,
                        input logic [15:0] d, input logic [1:0] be);
    m1_read = r; m1_write = w; m1_address = a; m1_writedata = d; m1_byteenable = be;
  endtask

  // Scoreboard monitors, sampled just after the active edge
  always @(posedge clk) begin
    #2;
    if (d1_rdv0 || d1_rdv1) begin
      if (q1.size() == 0) begin
        chk("d1_unexpected_rdv", {d1_rdv1, d1_rdv0}, 2'b00);
      end else begin
        e1 = q1.pop_front();
        chk("d1_rdv_id", {d1_rdv1, d1_rdv0}, e1[16] ? 2'b10 : 2'b01);
        chk("d1_rdata", e1[16] ? d1_rdata1 : d1_rdata0, e1[15:0]);
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (d2_rdv0 || d2_rdv1) begin
      if (q2.size() == 0) begin
        chk("d2_unexpected_rdv", {d2_rdv1, d2_rdv0}, 2'b00);
      end else begin
        e2 = q2.pop_front();
        chk("d2_rdv_id", {d2_rdv1, d2_rdv0}, e2[16] ? 2'b10 : 2'b01);
        chk("d2_rdata", e2[16] ? d2_rdata1 : d2_rdata0, e2[15:0]);
      end
    end
  end

  initial begin
    reset = 1'b1;
    reset_req = 1'b0;
    idle();
    set_m0(1'b1, 1'b0, 13'h0010, 16'h0, 2'b11);
    @(negedge clk); #1;
    chk("rst_wait0", d1_wait0, 1'b1);
    chk("rst_wait1", d1_wait1, 1'b0);
    chk("rst_cs", d1_cs, 1'b0);
    chk("rst_clken", d1_clken, 1'b1);
    @(negedge clk); #1;
    chk("rst_rdv", {d1_rdv1, d1_rdv0, d2_rdv1, d2_rdv0}, 4'b0);

    // Write then read back on m0
    reset = 1'b0;
    set_m0(1'b0, 1'b1, 13'h0010, 16'hA5C3, 2'b11);
    #1;
    chk("t1_wr_wait0", d1_wait0, 1'b0);
    chk("t1_wr_ram", {d1_cs, d1_wr, d1_addr, d1_wdata, d1_be}, {2'b11, 13'h0010, 16'hA5C3, 2'b11});
    @(negedge clk);
    set_m0(1'b1, 1'b0, 13'h0010, 16'h0, 2'b11);
    #1;
    chk("t1_rd_wait0", d1_wait0, 1'b0);
    chk("t1_rd_ram", {d1_cs, d1_wr, d1_addr}, {2'b10, 13'h0010});
    push_both(1'b0, 16'hA5C3);
    @(negedge clk);
    idle();
    #1;
    chk("t1_rdv", {d1_rdv1, d1_rdv0, d1_rdata0}, {2'b01, 16'hA5C3});

    // Preload, ending with an m1 grant so m0 wins the next contention
    @(negedge clk);
    set_m0(1'b0, 1'b1, 13'h0000, 16'h1111, 2'b11);
    @(negedge clk);
    idle();
    set_m1(1'b0, 1'b1, 13'h1FFF, 16'h2222, 2'b11);
    #1;
    chk("pre_m1_wait1", d1_wait1, 1'b0);

    // Continuous contention: strict alternation starting with m0
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_m0(1'b1, 1'b0, 13'h0000, 16'h0, 2'b11);
      set_m1(1'b1, 1'b0, 13'h1FFF, 16'h0, 2'b11);
      #1;
      chk($sformatf("t2_waits_%0d", k), {d1_wait1, d1_wait0}, (k % 2 == 1) ? 2'b01 : 2'b10);
      chk($sformatf("t2_addr_%0d", k), d1_addr, (k % 2 == 1) ? 13'h1FFF : 13'h0000);
      push_both(k % 2 == 1, (k % 2 == 1) ? 16'h2222 : 16'h1111);
    end

    // Byte enables on m1
    @(negedge clk);
    idle();
    set_m1(1'b0, 1'b1, 13'h0100, 16'hFFFF, 2'b11);
    @(negedge clk);
    set_m1(1'b0, 1'b1, 13'h0100, 16'h1200, 2'b10);
    #1;
    chk("t3_be", d1_be, 2'b10);
    @(negedge clk);
    set_m1(1'b1, 1'b0, 13'h0100, 16'h0, 2'b11);
    #1;
    chk("t3_rd_wait1", d1_wait1, 1'b0);
    push_both(1'b1, 16'h12FF);

    // reset_req: in-flight read completes, new requests stall
    @(negedge clk);
    idle();
    set_m0(1'b1, 1'b0, 13'h0010, 16'h0, 2'b11);
    push_both(1'b0, 16'hA5C3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      reset_req = 1'b1;
      #1;
      chk($sformatf("t4_wait0_%0d", k), d1_wait0, 1'b1);
      chk($sformatf("t4_ram_%0d", k), {d1_cs, d1_wr, d1_addr, d1_be, d1_wdata}, '0);
    end
    @(negedge clk);
    reset_req = 1'b0;
    #1;
    chk("t4_release", {d1_wait0, d1_cs}, 2'b01);
    push_both(1'b0, 16'hA5C3);

    // Reset one cycle after a granted read: latency-2 instance drops it
    @(negedge clk);
    set_m0(1'b1, 1'b0, 13'h0000, 16'h0, 2'b11);
    #1;
    chk("t5_wait0", d1_wait0, 1'b0);
    q1.push_back({1'b0, 16'h1111});
    @(negedge clk);
    idle();
    reset = 1'b1;
    #1;
    chk("t5_d1_rdv", d1_rdv0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5_d2_no_rdv", {d2_rdv1, d2_rdv0}, 2'b00);
    @(negedge clk);
    set_m0(1'b1, 1'b0, 13'h0000, 16'h0, 2'b11);
    set_m1(1'b1, 1'b0, 13'h1FFF, 16'h0, 2'b11);
    #1;
    chk("t5_first_m0", {d1_wait1, d1_wait0, d2_wait1, d2_wait0}, 4'b1010);
    push_both(1'b0, 16'h1111);
    @(negedge clk);
    #1;
    chk("t5_then_m1", {d1_wait1, d1_wait0}, 2'b01);
    push_both(1'b1, 16'h2222);

    // Illegal read+write on m0: write happens, read dropped
    @(negedge clk);
    idle();
    set_m0(1'b1, 1'b1, 13'h0005, 16'hBEEF, 2'b11);
    #1;
    chk("t6_ram", {d1_cs, d1_wr, d1_addr, d1_wdata}, {2'b11, 13'h0005, 16'hBEEF});
    @(negedge clk);
    set_m0(1'b1, 1'b0, 13'h0005, 16'h0, 2'b11);
    #1;
    chk("t6_no_rdv", {d1_rdv1, d1_rdv0}, 2'b00);
    push_both(1'b0, 16'hBEEF);
    @(negedge clk);
    idle();
    repeat (4) @(negedge clk);

    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
